// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared constants for the serial arithmetic blocks
package serial_addsub_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    function automatic int cnt_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/serial_addsub_if.sv
// serial_addsub_if: operand/result handshake bundle for serial_addsub
interface serial_addsub_if #(parameter int WIDTH = 8);
    logic             start, cin, sub, busy, done, cout, ovf;
    logic [WIDTH-1:0] a, b, sum;
    modport master(output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
    modport slave(input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_addsub_fa_cell.sv
// fa_cell: one-bit full adder
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle add/subtract, BPC bits per clock, LSB slice first
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input logic clk,
    input logic rst,
    serial_addsub_if.slave bus
);
    localparam int N  = WIDTH / BPC;
    localparam int CW = cnt_w(N);
    if (BPC < 1 || WIDTH < 1 || WIDTH % BPC != 0) begin : g_bad
        $error("serial_addsub: WIDTH must be a positive multiple of BPC");
    end
    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] ra, rb, racc, nxt;
    logic             c;
    logic [BPC:0]     ch;
    logic [BPC-1:0]   ss;
    assign ch[0] = c;
    for (genvar i = 0; i < BPC; i++) begin : g_fa
        fa_cell u_fa (.a(ra[i]), .b(rb[i]), .ci(ch[i]), .s(ss[i]), .co(ch[i+1]));
    end
    // operands shift down so the active slice is always at bit 0; results enter at the top
    assign nxt      = (racc >> BPC) | (WIDTH'(ss) << (WIDTH - BPC));
    assign bus.busy = state == RUN;
    assign bus.done = state == DONE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ra       <= '0;
            rb       <= '0;
            racc     <= '0;
            c        <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
        end else if (bus.start && state != RUN) begin
            state <= RUN;
            ra    <= bus.a;
            rb    <= bus.sub ? ~bus.b : bus.b;
            c     <= bus.cin ^ bus.sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            ra   <= ra >> BPC;
            rb   <= rb >> BPC;
            racc <= nxt;
            c    <= ch[BPC];
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(N - 1)) begin
                state    <= DONE;
                bus.sum  <= nxt;
                bus.cout <= ch[BPC];
                bus.ovf  <= ch[BPC] ^ ch[BPC-1];
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule
